// File: rtl/hzd_pkg.sv
// Shared types and encodings for the hazard scoreboard: NOUSE marker,
// forwarding-select encoding and the per-stage writer record.
package hzd_pkg;

  // Record fields are sized for the largest supported configuration.
  // Narrower instances zero-extend into the record.
  localparam int REG_AW_MAX = 8;
  localparam int TW_MAX     = 4;

  // fwd_sel value 0 selects the register file; k selects tracked stage k.
  localparam int SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] dst;
    logic [TW_MAX-1:0]     tnew;
  } stg_entry_t;

  // All-ones Tuse for a field of width tw: the source is never read.
  function automatic logic [TW_MAX-1:0] nouse(input int tw);
    return TW_MAX'((1 << tw) - 1);
  endfunction

  function automatic logic [TW_MAX-1:0] sat_dec(input logic [TW_MAX-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

endpackage

// File: rtl/hzd_port_chk.sv
// One D-stage read port: find the youngest in-flight writer of the source
// register, then decide between stalling, forwarding and the register file.
module hzd_port_chk
  import hzd_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int SW     = 2
) (
  input  logic                     d_valid_i,
  input  logic [REG_AW-1:0]        rsel_i,
  input  logic [TW-1:0]            tuse_i,
  input  logic [NSTAGE-1:0]        stg_valid_i,
  input  logic [NSTAGE*REG_AW-1:0] stg_dst_i,
  input  logic [NSTAGE*TW-1:0]     stg_tnew_i,
  output logic                     stall_o,
  output logic [SW-1:0]            sel_o
);

  localparam logic [TW-1:0] NOUSE_V = TW'(nouse(TW));

  logic          active;
  logic          hit;
  logic [SW-1:0] hit_idx;
  logic [TW-1:0] hit_tnew;

  assign active = d_valid_i && (tuse_i != NOUSE_V) && (rsel_i != '0);

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = SW'(SEL_RF);
    hit_tnew = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (stg_valid_i[k] && (stg_dst_i[k*REG_AW +: REG_AW] == rsel_i)) begin
        hit      = 1'b1;
        hit_idx  = SW'(k + 1);
        hit_tnew = stg_tnew_i[k*TW +: TW];
      end
    end
  end

  assign stall_o = active && hit && (hit_tnew > tuse_i);
  assign sel_o   = (active && hit && (hit_tnew == '0)) ? hit_idx : SW'(SEL_RF);

endmodule

// File: rtl/hzd_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks writers in E..W, stalls D on unmet
// operands and picks forwarding sources. HZD_MDU_EN adds an MDU busy interlock.
module hzd_scoreboard
  import hzd_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int NSTAGE = 3,
  parameter int NRP    = 2,
  parameter int TW     = 2,
`ifdef HZD_MDU_EN
  parameter int MD_LAT = 5,
`endif
  localparam int REG_AW = $clog2(NREG),
  localparam int SW     = $clog2(NSTAGE + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     d_valid,
  input  logic [NRP*REG_AW-1:0]    d_rsel,
  input  logic [NRP*TW-1:0]        d_tuse,
  input  logic                     d_wr,
  input  logic [REG_AW-1:0]        d_wdst,
  input  logic [TW-1:0]            d_tnew,
`ifdef HZD_MDU_EN
  input  logic                     md_start,
  input  logic                     md_use,
`endif
  output logic                     stall,
  output logic [NRP*SW-1:0]        fwd_sel,
  output logic [NSTAGE-1:0]        stg_valid,
  output logic [NSTAGE*REG_AW-1:0] stg_dst,
  output logic [NSTAGE*TW-1:0]     stg_tnew
);

  stg_entry_t stg_q [NSTAGE];
  stg_entry_t stg_d [NSTAGE];

  // Stage 1 takes D (or a bubble on stall); later stages always advance.
  always_comb begin
    stg_d[0] = '0;
    if (!stall) begin
      stg_d[0].valid = d_valid & d_wr & (d_wdst != '0);
      stg_d[0].dst   = REG_AW_MAX'(d_wdst);
      stg_d[0].tnew  = TW_MAX'(d_tnew);
    end
    for (int k = 1; k < NSTAGE; k++) begin
      stg_d[k]      = stg_q[k-1];
      stg_d[k].tnew = sat_dec(stg_q[k-1].tnew);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NSTAGE; k++) stg_q[k] <= '0;
    end else begin
      for (int k = 0; k < NSTAGE; k++) stg_q[k] <= stg_d[k];
    end
  end

  logic [NSTAGE-1:0] unused_hi;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_exp
    assign stg_valid[k]                = stg_q[k].valid;
    assign stg_dst[k*REG_AW +: REG_AW] = stg_q[k].dst[REG_AW-1:0];
    assign stg_tnew[k*TW +: TW]        = stg_q[k].tnew[TW-1:0];
    assign unused_hi[k]                = ^{stg_q[k].dst, stg_q[k].tnew};
  end

  logic [NRP-1:0] port_stall;

  for (genvar p = 0; p < NRP; p++) begin : g_port
    hzd_port_chk #(
      .NSTAGE(NSTAGE),
      .REG_AW(REG_AW),
      .TW    (TW),
      .SW    (SW)
    ) u_chk (
      .d_valid_i  (d_valid),
      .rsel_i     (d_rsel[p*REG_AW +: REG_AW]),
      .tuse_i     (d_tuse[p*TW +: TW]),
      .stg_valid_i(stg_valid),
      .stg_dst_i  (stg_dst),
      .stg_tnew_i (stg_tnew),
      .stall_o    (port_stall[p]),
      .sel_o      (fwd_sel[p*SW +: SW])
    );
  end

`ifdef HZD_MDU_EN
  localparam int MDW = $clog2(MD_LAT + 1);

  logic [MDW-1:0] md_cnt_q, md_cnt_d;
  logic           md_stall;

  assign md_stall = d_valid & md_use & (md_cnt_q != '0);
  assign stall    = (|port_stall) | md_stall;

  // A start is only taken when D actually issues.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (d_valid & md_start & ~stall) md_cnt_d = MDW'(MD_LAT);
    else if (md_cnt_q != '0)         md_cnt_d = md_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) md_cnt_q <= '0;
    else        md_cnt_q <= md_cnt_d;
  end
`else
  assign stall = |port_stall;
`endif

endmodule

// File: tb/tb_hzd_scoreboard.sv
// Directed bench for hzd_scoreboard; build with +define+HZD_MDU_EN to add the
// MDU interlock scenario.
module tb_hzd_scoreboard;

  localparam int NREG   = 32;
  localparam int NSTAGE = 3;
  localparam int NRP    = 2;
  localparam int TW     = 2;
  localparam int REG_AW = 5;
  localparam int SW     = 2;
  localparam int NOUSE  = 3;
`ifdef HZD_MDU_EN
  localparam int MD_LAT = 5;
`endif

  logic                     clk;
  logic                     reset;
  logic                     d_valid;
  logic [NRP*REG_AW-1:0]    d_rsel;
  logic [NRP*TW-1:0]        d_tuse;
  logic                     d_wr;
  logic [REG_AW-1:0]        d_wdst;
  logic [TW-1:0]            d_tnew;
`ifdef HZD_MDU_EN
  logic                     md_start;
  logic                     md_use;
`endif
  logic                     stall;
  logic [NRP*SW-1:0]        fwd_sel;
  logic [NSTAGE-1:0]        stg_valid;
  logic [NSTAGE*REG_AW-1:0] stg_dst;
  logic [NSTAGE*TW-1:0]     stg_tnew;

  hzd_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .d_valid  (d_valid),
    .d_rsel   (d_rsel),
    .d_tuse   (d_tuse),
    .d_wr     (d_wr),
    .d_wdst   (d_wdst),
    .d_tnew   (d_tnew),
`ifdef HZD_MDU_EN
    .md_start (md_start),
    .md_use   (md_use),
`endif
    .stall    (stall),
    .fwd_sel  (fwd_sel),
    .stg_valid(stg_valid),
    .stg_dst  (stg_dst),
    .stg_tnew (stg_tnew)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / compare ----------------
  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted write is remembered with the D cycle it issued in; its stage
  // and remaining latency follow from elapsed cycles alone.
  typedef struct {
    int c;
    int dst;
    int tnew;
  } wr_t;

  wr_t wq[$];
  int  cyc    = 0;
  int  md_end = -100;

  function automatic void model_eval(output logic st,
                                     output logic [NRP*SW-1:0] fs,
                                     output logic [NSTAGE-1:0] sv,
                                     output logic [NSTAGE*REG_AW-1:0] sd,
                                     output logic [NSTAGE*TW-1:0] stn);
    st = 1'b0; fs = '0; sv = '0; sd = '0; stn = '0;
    if (reset !== 1'b1) return;
    foreach (wq[i]) begin
      int s;
      int rem;
      s = cyc - wq[i].c;
      if (s >= 1 && s <= NSTAGE) begin
        rem = wq[i].tnew - (s - 1);
        if (rem < 0) rem = 0;
        sv[s-1] = 1'b1;
        sd[(s-1)*REG_AW +: REG_AW] = REG_AW'(wq[i].dst);
        stn[(s-1)*TW +: TW] = TW'(rem);
      end
    end
    if (d_valid) begin
      for (int p = 0; p < NRP; p++) begin
        int rs;
        int tu;
        int best;
        int brem;
        rs = int'(d_rsel[p*REG_AW +: REG_AW]);
        tu = int'(d_tuse[p*TW +: TW]);
        best = 0;
        brem = 0;
        if (tu != NOUSE && rs != 0) begin
          foreach (wq[i]) begin
            int s;
            int rem;
            s = cyc - wq[i].c;
            rem = wq[i].tnew - (s - 1);
            if (rem < 0) rem = 0;
            if (s >= 1 && s <= NSTAGE && wq[i].dst == rs && (best == 0 || s < best)) begin
              best = s;
              brem = rem;
            end
          end
          if (best != 0) begin
            if (brem > tu) st = 1'b1;
            if (brem == 0) fs[p*SW +: SW] = SW'(best);
          end
        end
      end
`ifdef HZD_MDU_EN
      if (md_use && cyc <= md_end) st = 1'b1;
`endif
    end
  endfunction

  logic                     u_st;
  logic [NRP*SW-1:0]        u_fs;
  logic [NSTAGE-1:0]        u_sv;
  logic [NSTAGE*REG_AW-1:0] u_sd;
  logic [NSTAGE*TW-1:0]     u_stn;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wq.delete();
      md_end = -100;
    end else begin
      model_eval(u_st, u_fs, u_sv, u_sd, u_stn);
      if (!u_st && d_valid && d_wr && d_wdst != 0)
        wq.push_back('{cyc, int'(d_wdst), int'(d_tnew)});
`ifdef HZD_MDU_EN
      if (d_valid && md_start && !u_st) md_end = cyc + MD_LAT;
`endif
      cyc++;
      while (wq.size() > 0 && cyc - wq[0].c > NSTAGE) void'(wq.pop_front());
    end
  end

  // Scoreboard compare on every falling edge once tracking has started.
  logic                     e_st;
  logic [NRP*SW-1:0]        e_fs;
  logic [NSTAGE-1:0]        e_sv;
  logic [NSTAGE*REG_AW-1:0] e_sd;
  logic [NSTAGE*TW-1:0]     e_stn;

  always @(negedge clk) begin
    if (chk_en) begin
      model_eval(e_st, e_fs, e_sv, e_sd, e_stn);
      cmp("model stall", 32'(stall), 32'(e_st));
      cmp("model fwd_sel", 32'(fwd_sel), 32'(e_fs));
      cmp("model stg_valid", 32'(stg_valid), 32'(e_sv));
      for (int k = 0; k < NSTAGE; k++) begin
        if (e_sv[k]) begin
          cmp("model stg_dst", 32'(stg_dst[k*REG_AW +: REG_AW]), 32'(e_sd[k*REG_AW +: REG_AW]));
          cmp("model stg_tnew", 32'(stg_tnew[k*TW +: TW]), 32'(e_stn[k*TW +: TW]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input int r0, input int u0, input int r1, input int u1,
                       input logic wr, input int wd, input int tn);
    d_valid = v;
    d_rsel  = {REG_AW'(r1), REG_AW'(r0)};
    d_tuse  = {TW'(u1), TW'(u0)};
    d_wr    = wr;
    d_wdst  = REG_AW'(wd);
    d_tnew  = TW'(tn);
  endtask

  task automatic idle();
    set_d(1'b0, 0, NOUSE, 0, NOUSE, 1'b0, 0, 0);
`ifdef HZD_MDU_EN
    md_start = 1'b0;
    md_use   = 1'b0;
`endif
  endtask

  task automatic flush();
    idle();
    repeat (NSTAGE + 1) tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0;
    idle();
    repeat (2) tick();
    cmp("reset stall", 32'(stall), 32'd0);
    cmp("reset stg_valid", 32'(stg_valid), 32'd0);
    cmp("reset fwd_sel", 32'(fwd_sel), 32'd0);
    reset  = 1'b1;
    chk_en = 1'b1;
    tick();

    // load-use: $8 tnew=2 then read with tuse=1
    set_d(1'b1, 0, NOUSE, 0, NOUSE, 1'b1, 8, 2);
    tick();
    set_d(1'b1, 8, 1, 0, NOUSE, 1'b0, 0, 0);
    #1 cmp("load-use stall", 32'(stall), 32'd1);
    tick();
    #1 cmp("load-use release", 32'(stall), 32'd0);
    cmp("load-use fwd", 32'(fwd_sel), 32'h0);
    tick();
    flush();

    // branch after ALU: $3 tnew=1 then read with tuse=0
    set_d(1'b1, 0, NOUSE, 0, NOUSE, 1'b1, 3, 1);
    tick();
    set_d(1'b1, 3, 0, 0, NOUSE, 1'b0, 0, 0);
    #1 cmp("branch stall", 32'(stall), 32'd1);
    tick();
    #1 cmp("branch release", 32'(stall), 32'd0);
    cmp("branch fwd M", 32'(fwd_sel), 32'h2);
    tick();
    flush();

    // zero register is never tracked
    set_d(1'b1, 0, NOUSE, 0, NOUSE, 1'b1, 0, 2);
    tick();
    #1 cmp("r0 stg_valid", 32'(stg_valid), 32'd0);
    set_d(1'b1, 0, 0, 0, 0, 1'b0, 0, 0);
    #1 cmp("r0 stall", 32'(stall), 32'd0);
    cmp("r0 fwd", 32'(fwd_sel), 32'h0);
    flush();

    // youngest wins on port 1; port 0 reads $5 but is NOUSE
    set_d(1'b1, 0, NOUSE, 0, NOUSE, 1'b1, 5, 0);
    tick();
    set_d(1'b1, 0, NOUSE, 0, NOUSE, 1'b1, 5, 0);
    tick();
    set_d(1'b1, 5, NOUSE, 5, 0, 1'b0, 0, 0);
    #1 cmp("youngest fwd", 32'(fwd_sel), 32'h4);
    cmp("youngest stall", 32'(stall), 32'd0);
    flush();

    // older busy writer is shadowed by a younger ready one
    set_d(1'b1, 0, NOUSE, 0, NOUSE, 1'b1, 6, 3);
    tick();
    set_d(1'b1, 0, NOUSE, 0, NOUSE, 1'b1, 6, 0);
    tick();
    set_d(1'b1, 6, 0, 0, NOUSE, 1'b0, 0, 0);
    #1 cmp("shadow stall", 32'(stall), 32'd0);
    cmp("shadow fwd", 32'(fwd_sel), 32'h1);
    flush();

    // d_valid=0 suppresses the hazard; raising it exposes the stall
    set_d(1'b1, 0, NOUSE, 0, NOUSE, 1'b1, 7, 3);
    tick();
    set_d(1'b0, 7, 0, 7, 0, 1'b0, 0, 0);
    #1 cmp("invalid D stall", 32'(stall), 32'd0);
    cmp("invalid D fwd", 32'(fwd_sel), 32'h0);
    d_valid = 1'b1;
    #1 cmp("valid D stall", 32'(stall), 32'd1);
    repeat (4) tick();
    flush();

    // reset mid-stall clears state without a clock edge
    set_d(1'b1, 0, NOUSE, 0, NOUSE, 1'b1, 9, 3);
    tick();
    set_d(1'b1, 9, 0, 0, NOUSE, 1'b0, 0, 0);
    #1 cmp("pre-reset stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1 cmp("mid-reset stall", 32'(stall), 32'd0);
    cmp("mid-reset stg_valid", 32'(stg_valid), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    #1 cmp("post-reset stall", 32'(stall), 32'd0);
    flush();

`ifdef HZD_MDU_EN
    // MDU: start, then a consumer waits MD_LAT cycles
    idle();
    d_valid  = 1'b1;
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    md_use   = 1'b1;
    for (int i = 0; i < MD_LAT; i++) begin
      #1 cmp("mdu stall", 32'(stall), 32'd1);
      tick();
    end
    #1 cmp("mdu release", 32'(stall), 32'd0);
    flush();
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hzd_scoreboard.md
HZD_SCOREBOARD -- requirements
Module: hzd_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, architectural register count; REG_AW = clog2(NREG).
REQ-002 SHALL have parameter NSTAGE, default 3, number of tracked stages after D (1=E, 2=M, 3=W).
REQ-003 SHALL have parameter NRP, default 2, number of D-stage read ports.
REQ-004 SHALL have parameter TW, default 2, width of Tuse/Tnew fields; Tuse all-ones = NOUSE.
REQ-005 SHALL have ports: clk in 1 clock; reset in 1, asynchronous, active-low.
REQ-006 SHALL have ports: d_valid in 1, D holds a real instruction; d_rsel in NRP*REG_AW, source register numbers; d_tuse in NRP*TW, cycles until each source is needed.
REQ-007 SHALL have ports: d_wr in 1; d_wdst in REG_AW; d_tnew in TW, cycles after E entry until the result exists.
REQ-008 SHALL have ports: stall out 1; fwd_sel out NRP*SW (SW = clog2(NSTAGE+1)), 0=RF, k=stage k.
REQ-009 SHALL have ports: stg_valid out NSTAGE; stg_dst out NSTAGE*REG_AW; stg_tnew out NSTAGE*TW, exported for downstream forwarding.

Function
REQ-010 SHALL hold per stage {valid, dst, tnew}; every cycle, stage k+1 takes stage k with tnew saturating-decremented to 0; last stage is discarded.
REQ-011 SHALL load stage 1 with {d_valid&d_wr&(d_wdst!=0), d_wdst, d_tnew} when stall=0, and with a bubble (valid=0) when stall=1; stages 2..NSTAGE advance regardless of stall.
REQ-012 SHALL, per port p with d_tuse!=NOUSE and d_rsel!=0, select the youngest (lowest k) valid stage whose dst equals d_rsel; older matches ignored.
REQ-013 SHALL assert stall combinationally when d_valid=1 and any selected stage has tnew > d_tuse of that port.
REQ-014 SHALL drive fwd_sel[p]=k when the selected stage has tnew=0, else 0; 0 when no match.
REQ-015 SHALL never stall or forward for register 0, NOUSE ports, or d_valid=0.
REQ-016 SHALL treat a write to register 0 as no write (stage valid=0).
REQ-017 SHALL have zero latency from inputs to stall/fwd_sel; state updates on the rising clk edge only.

Reset
REQ-018 SHALL, while reset=0, clear all stage valid/dst/tnew to 0 immediately; stall=0 and fwd_sel=0 follow combinationally.
REQ-019 SHALL resume tracking on the first rising edge after reset releases; reset asserted mid-stall discards the stall.

Configuration
REQ-020 SHALL, with HZD_MDU_EN defined, add parameter MD_LAT (default 5), inputs md_start and md_use (1 each), and an MDU busy down-counter.
REQ-021 SHALL, with HZD_MDU_EN, load the counter with MD_LAT when d_valid&md_start&~stall, decrement to 0 otherwise, and additionally stall when d_valid&md_use and counter!=0.
REQ-022 SHALL, without HZD_MDU_EN, omit MD_LAT, md_start, md_use and the counter; stall depends only on REQ-013.

Structure
REQ-023 SHALL place NOUSE, fwd_sel encodings (SEL_RF=0, stage indices) and the stage-entry record typedef in package hzd_pkg.
REQ-024 SHALL implement per-port match/priority/compare as sub-module hzd_port_chk, instantiated NRP times.

Verification
REQ-025 SHALL pass load-use: D writes $8 tnew=2, next D reads $8 tuse=1 -> stall=1 exactly 1 cycle, then stall=0 with fwd_sel=0.
REQ-026 SHALL pass branch-after-ALU: D writes $3 tnew=1, next D reads $3 tuse=0 -> stall 1 cycle, then fwd_sel=2.
REQ-027 SHALL pass zero register: write $0 tnew=2, then read $0 tuse=0 -> stall=0, fwd_sel=0.
REQ-028 SHALL pass youngest-wins: stages 1 and 2 both hold $5 tnew=0, D reads $5 -> fwd_sel=1.
REQ-029 SHALL pass reset mid-stall: assert reset=0 while stall=1 -> stall=0 and stg_valid=0 without a clock edge.
REQ-030 SHALL pass HZD_MDU_EN with MD_LAT=5: md_start, then md_use next cycle -> stall=1 for 5 cycles.
